// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding LDR/STR controller between execute and writeback.
// It drives a req/ack memory bus. Define MEMCTRL_TIMEOUT_EN to abort bus cycles that never see mem_ack.
module mem_access_ctrl #(
    parameter int                  ADDR_W         = 32,
    parameter int                  DATA_W         = 32,
    parameter int                  OPCODE_W       = 4,
    parameter logic [OPCODE_W-1:0] OP_LDR         = OPCODE_W'(4'b1101),
    parameter logic [OPCODE_W-1:0] OP_STR         = OPCODE_W'(4'b1110),
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPCODE_W-1:0] req_opcode,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    output logic                mem_req,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                ld_valid,
    input  logic                ld_ready,
    output logic [DATA_W-1:0]   ld_data,
    output logic                str_done,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_nxt;
    logic   is_ldr_op;
    logic   accept;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign is_ldr_op = (req_opcode == OP_LDR);
    // Unknown opcodes are still consumed by the handshake; they just never reach the bus.
    assign accept    = req_valid && req_ready && (is_ldr_op || req_opcode == OP_STR);
    assign busy      = (state != IDLE);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th bus cycle without an ack; an ack in that cycle wins.
    assign timeout = (state == BUS) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout;
            if (accept)
                wait_cnt <= '0;
            else if (state == BUS && !mem_ack)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        ld_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept)
                    state_nxt = BUS;
            end
            BUS: begin
                mem_req = 1'b1;
                if (mem_ack || timeout)
                    state_nxt = mem_rw ? RESP : IDLE;
            end
            RESP: begin
                ld_valid = 1'b1;
                if (ld_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_data   <= '0;
            str_done  <= 1'b0;
        end else begin
            str_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mem_rw    <= is_ldr_op;
                        mem_addr  <= req_addr;
                        mem_wdata <= is_ldr_op ? '0 : req_data;
                    end
                end
                BUS: begin
                    if (mem_ack) begin
                        if (mem_rw)
                            ld_data <= mem_rdata;
                        else
                            str_done <= 1'b1;
                    end else if (timeout && mem_rw) begin
                        ld_data <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a random back-to-back run.
// Bus and load expectations are queued when a request is driven and popped when the DUT responds.
module tb_mem_access_ctrl;

    localparam int         AW  = 32;
    localparam int         DW  = 32;
    localparam logic [3:0] LDR = 4'b1101;
    localparam logic [3:0] STR = 4'b1110;
    localparam int         TMO = 16;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_opcode;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          mem_req;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          str_done;
    logic          busy;
    logic          err;

    bus_exp_t      bus_q[$];
    logic [DW-1:0] ld_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .OPCODE_W(4),
        .OP_LDR(LDR), .OP_STR(STR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_data(req_data),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .str_done(str_done), .busy(busy), .err(err)
    );

    // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle and queue what the bus and writeback should see.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] rdata);
        bus_exp_t e;
        req_valid  = 1'b1;
        req_opcode = op;
        req_addr   = addr;
        req_data   = data;
        if (op == LDR || op == STR) begin
            e.rw    = (op == LDR);
            e.addr  = addr;
            e.wdata = (op == LDR) ? '0 : data;
            bus_q.push_back(e);
            if (op == LDR)
                ld_q.push_back(rdata);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_opcode = '0; req_addr = '0; req_data = '0;
        mem_rdata = '0; mem_ack = 1'b0; ld_ready = 1'b0;
        tick();
        n_cmp++;
        if ({req_ready, busy, mem_req, mem_rw, ld_valid, str_done, err} !== 7'b1001000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {req_ready, busy, mem_req, mem_rw, ld_valid, str_done, err}, 7'b1001000);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, ld_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h/%h/%h expected all zero", mem_addr, mem_wdata, ld_data);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({req_ready, busy, mem_req, ld_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", {req_ready, busy, mem_req, ld_valid}, 4'b1000);
        end
    endtask

    task automatic test_ldr_zero_wait();
        bus_exp_t      e;
        logic [DW-1:0] exp_d;
        ld_ready = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ldr_ready_idle: got %b expected 1", req_ready);
        end
        issue(LDR, 32'h12345678, 32'h5555AAAA, 32'hCAFEBABE);
        e = bus_q.pop_front();
        n_cmp++;
        if ({mem_req, mem_rw, mem_addr, mem_wdata, req_ready, busy} !== {1'b1, e.rw, e.addr, e.wdata, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ldr_bus: got req=%b rw=%b addr=%h wdata=%h rdy=%b busy=%b expected req=1 rw=%b addr=%h wdata=%h rdy=0 busy=1",
                     mem_req, mem_rw, mem_addr, mem_wdata, req_ready, busy, e.rw, e.addr, e.wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEBABE;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        exp_d = ld_q.pop_front();
        n_cmp++;
        if ({ld_valid, ld_data, mem_req, str_done} !== {1'b1, exp_d, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ldr_resp: got valid=%b data=%h req=%b sd=%b expected valid=1 data=%h req=0 sd=0",
                     ld_valid, ld_data, mem_req, str_done, exp_d);
        end
        tick();
        n_cmp++;
        if ({busy, ld_valid, req_ready, ld_data} !== {3'b001, exp_d}) begin
            n_err++;
            $display("FAIL ldr_idle: got busy=%b valid=%b rdy=%b data=%h expected busy=0 valid=0 rdy=1 data=%h",
                     busy, ld_valid, req_ready, ld_data, exp_d);
        end
    endtask

    task automatic test_str_wait_states();
        bus_exp_t e;
        issue(STR, 32'h12345678, 32'h9ABCDEF0, '0);
        e = bus_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({mem_req, mem_rw, mem_addr, mem_wdata, str_done, ld_valid} !== {1'b1, e.rw, e.addr, e.wdata, 2'b00}) begin
                n_err++;
                $display("FAIL str_bus_c%0d: got req=%b rw=%b addr=%h wdata=%h sd=%b lv=%b expected req=1 rw=%b addr=%h wdata=%h sd=0 lv=0",
                         i, mem_req, mem_rw, mem_addr, mem_wdata, str_done, ld_valid, e.rw, e.addr, e.wdata);
            end
            mem_ack = (i == 3);
            tick();
        end
        mem_ack = 1'b0;
        n_cmp++;
        if ({str_done, req_ready, mem_req, ld_valid} !== 4'b1100) begin
            n_err++;
            $display("FAIL str_done: got %b expected %b", {str_done, req_ready, mem_req, ld_valid}, 4'b1100);
        end
        tick();
        n_cmp++;
        if ({str_done, ld_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL str_pulse: got %b expected %b", {str_done, ld_valid, busy}, 3'b000);
        end
    endtask

    task automatic test_ld_backpressure();
        logic [DW-1:0] exp_d;
        ld_ready = 1'b0;
        issue(LDR, 32'h0000_0400, '0, 32'h0BAD_F00D);
        void'(bus_q.pop_front());
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000;
        exp_d = ld_q[0];
        req_valid = 1'b1; req_opcode = LDR; req_addr = 32'h0000_0800;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({ld_valid, ld_data, req_ready, mem_req} !== {1'b1, exp_d, 2'b00}) begin
                n_err++;
                $display("FAIL ld_hold_c%0d: got valid=%b data=%h rdy=%b req=%b expected valid=1 data=%h rdy=0 req=0",
                         i, ld_valid, ld_data, req_ready, mem_req, exp_d);
            end
            tick();
        end
        req_valid = 1'b0;
        ld_ready  = 1'b1;
        exp_d = ld_q.pop_front();
        n_cmp++;
        if ({ld_valid, ld_data} !== {1'b1, exp_d}) begin
            n_err++;
            $display("FAIL ld_handshake: got valid=%b data=%h expected valid=1 data=%h", ld_valid, ld_data, exp_d);
        end
        tick();
        n_cmp++;
        if ({busy, mem_req, ld_valid, req_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL ld_no_accept: got %b expected %b", {busy, mem_req, ld_valid, req_ready}, 4'b0001);
        end
    endtask

    task automatic test_bad_opcode();
        bus_exp_t e;
        issue(4'b0000, 32'hFFFF_0000, 32'h1111_2222, '0);
        n_cmp++;
        if ({mem_req, busy, ld_valid, str_done, req_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL bad_op: got %b expected %b", {mem_req, busy, ld_valid, str_done, req_ready}, 5'b00001);
        end
        ld_ready = 1'b1;
        issue(LDR, 32'h0000_00F0, '0, 32'h7777_8888);
        e = bus_q.pop_front();
        n_cmp++;
        if ({mem_req, mem_rw, mem_addr} !== {1'b1, e.rw, e.addr}) begin
            n_err++;
            $display("FAIL bad_op_next: got req=%b rw=%b addr=%h expected req=1 rw=%b addr=%h",
                     mem_req, mem_rw, mem_addr, e.rw, e.addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({ld_valid, ld_data} !== {1'b1, ld_q[0]}) begin
            n_err++;
            $display("FAIL bad_op_ld: got valid=%b data=%h expected valid=1 data=%h", ld_valid, ld_data, ld_q[0]);
        end
        void'(ld_q.pop_front());
        tick();
    endtask

    task automatic test_reset_mid_bus();
        issue(STR, 32'hA000_0010, 32'h1357_9BDF, '0);
        tick();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: got mem_req=%b expected 1", mem_req);
        end
        reset = 1'b1;
        #1;
        void'(bus_q.pop_front());
        n_cmp++;
        if ({mem_req, busy, str_done, req_ready, mem_rw, mem_addr, mem_wdata} !== {5'b00011, {AW{1'b0}}, {DW{1'b0}}}) begin
            n_err++;
            $display("FAIL rst_mid: got req=%b busy=%b sd=%b rdy=%b rw=%b addr=%h wdata=%h expected 0 0 0 1 1 0 0",
                     mem_req, busy, str_done, req_ready, mem_rw, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({req_ready, busy, mem_req, str_done, ld_valid} !== 5'b10000) begin
            n_err++;
            $display("FAIL rst_after: got %b expected %b", {req_ready, busy, mem_req, str_done, ld_valid}, 5'b10000);
        end
    endtask

    task automatic test_back_to_back();
        bus_exp_t      e;
        logic [3:0]    op;
        logic [DW-1:0] rd;
        int            w;
        int            stall;
        for (int t = 0; t < 10; t++) begin
            op = ($urandom_range(0, 1) == 1) ? LDR : STR;
            rd = $urandom;
            issue(op, $urandom, $urandom, rd);
            e = bus_q[0];
            w = $urandom_range(0, 3);
            for (int i = 0; i <= w; i++) begin
                n_cmp++;
                if ({mem_req, mem_rw, mem_addr, mem_wdata, str_done, ld_valid} !== {1'b1, e.rw, e.addr, e.wdata, 2'b00}) begin
                    n_err++;
                    $display("FAIL b2b_bus_t%0d: got req=%b rw=%b addr=%h wdata=%h sd=%b lv=%b expected req=1 rw=%b addr=%h wdata=%h sd=0 lv=0",
                             t, mem_req, mem_rw, mem_addr, mem_wdata, str_done, ld_valid, e.rw, e.addr, e.wdata);
                end
                mem_ack   = (i == w);
                mem_rdata = (i == w) ? rd : ~rd;
                tick();
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            void'(bus_q.pop_front());
            if (e.rw) begin
                stall = $urandom_range(0, 2);
                ld_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    n_cmp++;
                    if ({ld_valid, ld_data} !== {1'b1, ld_q[0]}) begin
                        n_err++;
                        $display("FAIL b2b_stall_t%0d: got valid=%b data=%h expected valid=1 data=%h",
                                 t, ld_valid, ld_data, ld_q[0]);
                    end
                    tick();
                end
                ld_ready = 1'b1;
                n_cmp++;
                if ({ld_valid, ld_data} !== {1'b1, ld_q[0]}) begin
                    n_err++;
                    $display("FAIL b2b_ld_t%0d: got valid=%b data=%h expected valid=1 data=%h",
                             t, ld_valid, ld_data, ld_q[0]);
                end
                void'(ld_q.pop_front());
                tick();
            end else begin
                n_cmp++;
                if ({str_done, req_ready, ld_valid} !== 3'b110) begin
                    n_err++;
                    $display("FAIL b2b_st_t%0d: got %b expected %b", t, {str_done, req_ready, ld_valid}, 3'b110);
                end
            end
        end
        tick();
    endtask

`ifdef MEMCTRL_TIMEOUT_EN
    task automatic test_timeout();
        ld_ready = 1'b0;
        issue(LDR, 32'h4000_0000, '0, 32'hFFFF_FFFF);
        void'(bus_q.pop_front());
        for (int i = 0; i < TMO; i++) begin
            n_cmp++;
            if ({mem_req, err} !== 2'b10) begin
                n_err++;
                $display("FAIL tmo_wait_c%0d: got req=%b err=%b expected req=1 err=0", i, mem_req, err);
            end
            tick();
        end
        n_cmp++;
        if ({err, mem_req, ld_valid, ld_data} !== {3'b101, ld_q[0]}) begin
            n_err++;
            $display("FAIL tmo_abort: got err=%b req=%b valid=%b data=%h expected err=1 req=0 valid=1 data=%h",
                     err, mem_req, ld_valid, ld_data, ld_q[0]);
        end
        void'(ld_q.pop_front());
        ld_ready = 1'b1;
        tick();
        n_cmp++;
        if ({err, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL tmo_pulse: got err=%b busy=%b expected 0 0", err, busy);
        end
        issue(STR, 32'h4000_0004, 32'h0F0F_0F0F, '0);
        void'(bus_q.pop_front());
        for (int i = 0; i < TMO; i++) begin
            mem_ack = (i == TMO - 1);
            tick();
        end
        mem_ack = 1'b0;
        n_cmp++;
        if ({str_done, err, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL tmo_ack_wins: got sd=%b err=%b busy=%b expected 1 0 0", str_done, err, busy);
        end
        tick();
    endtask
`else
    task automatic test_timeout();
        ld_ready = 1'b1;
        issue(LDR, 32'h4000_0000, '0, 32'h2468_ACE0);
        void'(bus_q.pop_front());
        for (int i = 0; i < TMO + 4; i++) begin
            n_cmp++;
            if ({mem_req, err, ld_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL notmo_wait_c%0d: got req=%b err=%b lv=%b expected 1 0 0", i, mem_req, err, ld_valid);
            end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if ({ld_valid, ld_data, err} !== {1'b1, ld_q[0], 1'b0}) begin
            n_err++;
            $display("FAIL notmo_ld: got valid=%b data=%h err=%b expected valid=1 data=%h err=0",
                     ld_valid, ld_data, err, ld_q[0]);
        end
        void'(ld_q.pop_front());
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        test_reset();
        test_ldr_zero_wait();
        test_str_wait_states();
        test_ld_backpressure();
        test_bad_opcode();
        test_reset_mid_bus();
        test_back_to_back();
        test_timeout();
        n_cmp++;
        if (bus_q.size() != 0 || ld_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d bus / %0d load left expected 0 / 0", bus_q.size(), ld_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequential, parametrised successor to the combinational LDR/STR memory controller. Accepts one load/store request at a time from the execute stage over a valid/ready handshake. Drives a request/acknowledge memory bus with variable wait states and returns load data over a second valid/ready handshake. Sits between execute and writeback and asserts busy so the pipeline can stall.

Parameters:
ADDR_W, 32, address bus width
DATA_W, 32, data bus width
OPCODE_W, 4, opcode field width
OP_LDR, 4'b1101, load opcode
OP_STR, 4'b1110, store opcode
TIMEOUT_CYCLES, 16, bus cycles without mem_ack before abort (used only with MEMCTRL_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_opcode  input  OPCODE_W  instruction opcode
req_addr  input  ADDR_W  effective address
req_data  input  DATA_W  store data
mem_req  output  1  bus transaction active
mem_rw  output  1  1 = read (LDR), 0 = write (STR)
mem_addr  output  ADDR_W  bus address
mem_wdata  output  DATA_W  bus write data
mem_rdata  input  DATA_W  bus read data, valid with mem_ack
mem_ack  input  1  memory completes transaction this cycle
ld_valid  output  1  load result available
ld_ready  input  1  writeback accepts load result
ld_data  output  DATA_W  load result for destination register
str_done  output  1  one-cycle pulse, store completed
busy  output  1  state != IDLE
err  output  1  one-cycle pulse, bus timeout (always 0 without macro)

Behaviour:
- FSM states: IDLE, BUS, RESP. All outputs come from registers or state (Moore); no input-to-output combinational path.
- Reset values: state=IDLE, mem_req=0, mem_rw=1, mem_addr=0, mem_wdata=0, ld_valid=0, ld_data=0, str_done=0, err=0, busy=0. req_ready=1 in IDLE.
- IDLE: req_ready=1.
  - req_valid=1 with opcode OP_LDR or OP_STR: latch opcode, address and data (wdata forced to 0 for LDR), then go to BUS.
  - Handshake with any other opcode: consumed, no bus activity, no response, stay IDLE.
- BUS: mem_req=1; mem_rw and mem_addr/mem_wdata hold latched values and stay stable until mem_ack. req_ready=0.
  - mem_ack=1 with LDR: capture mem_rdata into ld_data, go to RESP.
  - mem_ack=1 with STR: str_done=1 for the next cycle, go to IDLE.
  - mem_ack while not in BUS is ignored.
- RESP: ld_valid=1 and ld_data held until ld_valid&&ld_ready; then go to IDLE. ld_data keeps its last value afterwards.
- Latency, zero-wait memory (mem_ack in first BUS cycle):
  - Accepted on edge N. mem_req high in cycle N+1.
  - LDR: ld_valid high in cycle N+2. With ld_ready=1, IDLE again in cycle N+3.
  - STR: str_done and req_ready high in cycle N+2.
  - Each wait state adds one cycle.
- No request pipelining: at most one outstanding transaction.
- Reset mid-operation: immediate return to reset values, mem_req drops without waiting for mem_ack, any pending load result is discarded.

Optional Feature:
MEMCTRL_TIMEOUT_EN.
- Defined: a counter clears on BUS entry and increments each BUS cycle without mem_ack. When it reaches TIMEOUT_CYCLES, the transaction aborts:
  - mem_req drops and err pulses for 1 cycle.
  - LDR: goes to RESP with ld_data = all ones.
  - STR: returns to IDLE without str_done.
  - mem_ack in the same cycle as the timeout wins (normal completion).
- Undefined: no counter, BUS waits indefinitely, err tied 0.

Test Plan:
1. LDR, opcode 4'b1101, addr 32'h12345678, mem_ack on 1st BUS cycle with rdata 32'hCAFEBABE, ld_ready=1 -> mem_rw=1, mem_addr=32'h12345678, ld_valid in cycle N+2 with ld_data=32'hCAFEBABE, busy low in cycle N+3.
2. STR, opcode 4'b1110, addr 32'h12345678, data 32'h9ABCDEF0, 3 wait states -> mem_rw=0, mem_wdata=32'h9ABCDEF0 stable 4 cycles, str_done single pulse, no ld_valid.
3. LDR with ld_ready held low 5 cycles -> ld_valid and ld_data held stable, req_ready=0 throughout, new req_valid not accepted.
4. Opcode 4'b0000 with req_valid=1 -> mem_req stays 0, no ld_valid/str_done, next LDR accepted on the following cycle.
5. reset asserted during BUS of a STR -> mem_req, busy and str_done 0 immediately; after release, IDLE with req_ready=1.
6. (MEMCTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16) LDR with mem_ack never asserted -> err pulse after 16 BUS cycles, ld_valid with ld_data=32'hFFFFFFFF.
